// File: rtl/dsp_pkg.sv
// Shared DSP definitions: accumulator/sample widths and the 17-bit output clip
// used by the CIC and the halfband/FIR output stages.
`timescale 1ns/1ps
package dsp_pkg;

    localparam int unsigned ACC_W = 27;
    localparam int unsigned OUT_W = 17;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef struct packed {
        logic signed [OUT_W-1:0] y;
        logic                    clip;
    } sat17_t;

    // Clip a sign-extended value into [-2**(OUT_W-1), 2**(OUT_W-1)-1].
    function automatic sat17_t sat17(input logic signed [ACC_W-1:0] v);
        sat17_t r;
        r.clip = 1'b0;
        r.y    = v[OUT_W-1:0];
        if (v > SAT_MAX) begin
            r.y    = SAT_MAX[OUT_W-1:0];
            r.clip = 1'b1;
        end else if (v < SAT_MIN) begin
            r.y    = SAT_MIN[OUT_W-1:0];
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: modulo difference against a delay register, updated only when
// a decimated sample arrives; valid is passed through with one cycle of delay.
`timescale 1ns/1ps
module cic_comb_stage #(
    parameter int unsigned W = 27
) (
    input  logic         CICCLK,
    input  logic         RST,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [W-1:0] dly;

    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) begin
            dly       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data - dly;
                dly      <= in_data;
            end
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: 1-bit PDM in, 17-bit signed PCM out at 1/DECIM rate.
// ACC_W in dsp_pkg must cover 2 + ORDER*log2(DECIM) bits.
`timescale 1ns/1ps
module cic_decimator
    import dsp_pkg::*;
#(
    parameter int unsigned ORDER = 5,
    parameter int unsigned DECIM = 32
) (
    input  logic                    CICCLK,
    input  logic                    RST,
    input  logic                    pdm_en,
    input  logic                    pdm_in,
    output logic signed [OUT_W-1:0] y_out,
    output logic                    y_valid,
    output logic                    sat
);

    localparam int unsigned PH_W  = $clog2(DECIM);
    localparam int unsigned SHIFT = ACC_W - 1 - OUT_W;

    logic        [PH_W-1:0]  phase;
    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] integ      [ORDER];
    logic signed [ACC_W-1:0] integ_next [ORDER];
    logic                    dec_stb;

    logic        [ACC_W-1:0] c_data [ORDER+1];
    logic                    c_vld  [ORDER+1];
    logic signed [ACC_W-1:0] shifted;
    sat17_t                  clip_res;

    assign x       = pdm_in ? ACC_W'(1) : '1;
    assign dec_stb = pdm_en && (phase == PH_W'(DECIM - 1));

    always_comb begin
        integ_next[0] = integ[0] + x;
        for (int unsigned k = 1; k < ORDER; k++) begin
            integ_next[k] = integ[k] + integ[k-1];
        end
    end

    // Integrators wrap freely; the comb differences undo the wrap.
    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
            end
            phase <= '0;
        end else if (pdm_en) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                integ[k] <= integ_next[k];
            end
            phase <= phase + PH_W'(1);
        end
    end

    // Comb 0 takes the post-update last integrator so the frame's final bit counts.
    assign c_data[0] = integ_next[ORDER-1];
    assign c_vld[0]  = dec_stb;

    for (genvar k = 0; k < ORDER; k++) begin : g_comb
        cic_comb_stage #(
            .W(ACC_W)
        ) u_comb (
            .CICCLK   (CICCLK),
            .RST      (RST),
            .in_valid (c_vld[k]),
            .in_data  (c_data[k]),
            .out_valid(c_vld[k+1]),
            .out_data (c_data[k+1])
        );
    end

    always_comb begin
        shifted  = $signed(c_data[ORDER]) >>> SHIFT;
        clip_res = sat17(shifted);
    end

    always_ff @(posedge CICCLK or posedge RST) begin
        if (RST) begin
            y_out   <= '0;
            y_valid <= 1'b0;
            sat     <= 1'b0;
        end else begin
            y_valid <= c_vld[ORDER];
            if (c_vld[ORDER]) begin
                y_out <= clip_res.y;
                if (clip_res.clip) begin
                    sat <= 1'b1;
                end
            end
        end
    end

endmodule
